// File: rtl/puf_challenge_sequencer.sv
// Initiator-side sequencer for a DelayPUF responder: walks RESP_BITS challenges
// from a base value, majority-votes VOTES evaluations each, and packs the result.
module puf_challenge_sequencer #(
  parameter int unsigned CHAL_W    = 8,
  parameter int unsigned RESP_BITS = 8,
  parameter int unsigned VOTES     = 3,
  parameter int unsigned SETTLE    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    base_challenge,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 puf_reset,
  output logic                 puf_run,
  output logic [CHAL_W-1:0]    puf_challenge,
  input  logic                 puf_result
);

  localparam int unsigned ONES_W = $clog2(VOTES + 1);
  localparam int unsigned IDX_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned VOTE_W = (VOTES > 1) ? $clog2(VOTES) : 1;
  localparam int unsigned SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(RESP_BITS - 1);
  localparam logic [VOTE_W-1:0] VOTE_LAST = VOTE_W'(VOTES - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE - 1);
  localparam logic [ONES_W-1:0] HALF      = ONES_W'(VOTES / 2);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ARM,
    RUN,
    SAMPLE,
    DONE
  } state_t;

  state_t               state, state_n;
  logic [CHAL_W-1:0]    chal, chal_n;
  logic [IDX_W-1:0]     chal_idx, chal_idx_n;
  logic [VOTE_W-1:0]    vote_idx, vote_idx_n;
  logic [ONES_W-1:0]    ones, ones_n, ones_sum;
  logic [SET_W-1:0]     settle_cnt, settle_cnt_n;
  logic [RESP_BITS-1:0] shreg, shreg_n;

  logic                 busy_n, done_n, puf_reset_n, puf_run_n;
  logic [RESP_BITS-1:0] response_n;
  logic [CHAL_W-1:0]    puf_challenge_n;

  assign ones_sum = ones + ONES_W'(puf_result);

  always_comb begin
    state_n      = state;
    chal_n       = chal;
    chal_idx_n   = chal_idx;
    vote_idx_n   = vote_idx;
    ones_n       = ones;
    settle_cnt_n = settle_cnt;
    shreg_n      = shreg;

    case (state)
      IDLE: begin
        if (start) begin
          chal_n     = base_challenge;
          chal_idx_n = '0;
          vote_idx_n = '0;
          ones_n     = '0;
          shreg_n    = '0;
          state_n    = SETUP;
        end
      end
      SETUP: state_n = ARM;
      ARM: begin
        settle_cnt_n = '0;
        state_n      = RUN;
      end
      RUN: begin
        if (settle_cnt == SET_LAST) state_n = SAMPLE;
        else settle_cnt_n = settle_cnt + SET_W'(1);
      end
      SAMPLE: begin
        if (vote_idx < VOTE_LAST) begin
          vote_idx_n = vote_idx + VOTE_W'(1);
          ones_n     = ones_sum;
          state_n    = SETUP;
        end else begin
          shreg_n[chal_idx] = (ones_sum > HALF);
          vote_idx_n        = '0;
          ones_n            = '0;
          if (chal_idx == IDX_LAST) begin
            state_n = DONE;
          end else begin
            chal_idx_n = chal_idx + IDX_W'(1);
            chal_n     = chal + CHAL_W'(1);
            state_n    = SETUP;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every pin
  // changes on the same edge as the state it reflects.
  always_comb begin
    busy_n          = (state_n != IDLE);
    done_n          = (state_n == DONE);
    puf_run_n       = (state_n == RUN);
    puf_reset_n     = (state_n == IDLE) || (state_n == SETUP) || (state_n == DONE);
    puf_challenge_n = (state_n == SETUP) ? chal_n : puf_challenge;
    response_n      = response;
    if (state == IDLE && start) response_n = '0;
    else if (state_n == DONE)   response_n = shreg_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      chal          <= '0;
      chal_idx      <= '0;
      vote_idx      <= '0;
      ones          <= '0;
      settle_cnt    <= '0;
      shreg         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      response      <= '0;
      puf_reset     <= 1'b1;
      puf_run       <= 1'b0;
      puf_challenge <= '0;
    end else begin
      state         <= state_n;
      chal          <= chal_n;
      chal_idx      <= chal_idx_n;
      vote_idx      <= vote_idx_n;
      ones          <= ones_n;
      settle_cnt    <= settle_cnt_n;
      shreg         <= shreg_n;
      busy          <= busy_n;
      done          <= done_n;
      response      <= response_n;
      puf_reset     <= puf_reset_n;
      puf_run       <= puf_run_n;
      puf_challenge <= puf_challenge_n;
    end
  end

endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
Initiator-side controller for a DelayPUF-style responder (clk/reset/a_run/a_challenge/result). On a start command it issues RESP_BITS consecutive challenges from a base value. Each challenge is evaluated VOTES times, and the single-bit results are majority-voted. The voted bits are packed into a response word, so a host (LA or wishbone glue) can fetch a stable multi-bit PUF response without bit-banging run/reset.

Parameters:
CHAL_W, 8, challenge width; matches the PUF a_challenge width.
RESP_BITS, 8, number of challenges per request, which is also the response width.
VOTES, 3, evaluations per challenge; must be odd and >= 1.
SETTLE, 4, cycles puf_run is held high before the result is sampled; must be >= 1.

Ports:
clk  input  1  system clock (wb_clk_i at the wrapper).
reset  input  1  synchronous, active-high reset.
start  input  1  request pulse; honoured only when busy=0.
base_challenge  input  CHAL_W  first challenge; sampled on the accepted start.
busy  output  1  high from the cycle after start is accepted until the done cycle inclusive.
done  output  1  one-cycle pulse; response is valid from this cycle.
response  output  RESP_BITS  voted response; bit i corresponds to challenge base+i (LSB first).
puf_reset  output  1  drives the PUF reset.
puf_run  output  1  drives the PUF a_run.
puf_challenge  output  CHAL_W  drives the PUF a_challenge.
puf_result  input  1  PUF result bit.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, response=0, puf_run=0, puf_challenge=0, puf_reset=1. FSM returns to IDLE and all counters clear.
- Reset mid-operation aborts the request immediately. No done pulse is produced, and response is cleared to 0.
- States: IDLE, SETUP, ARM, RUN, SAMPLE, DONE.
- IDLE:
  - puf_reset=1, puf_run=0.
  - When start=1 at a clock edge: latch base_challenge into chal, clear chal_idx, vote_idx, ones and the shift register, then go to SETUP. busy=1 from the next cycle.
- SETUP (1 cycle): puf_challenge=chal, puf_reset=1, puf_run=0 -> ARM.
- ARM (1 cycle): puf_reset=0, puf_run=0 -> RUN.
- RUN (SETTLE cycles, timed by a settle counter): puf_run=1 -> SAMPLE.
- SAMPLE (1 cycle):
  - puf_run=0; puf_result is sampled at the closing edge; ones_next = ones + puf_result.
  - If vote_idx < VOTES-1: vote_idx++, ones=ones_next -> SETUP.
  - Otherwise the voted bit is (ones_next > VOTES/2), using integer division. The bit is written to position chal_idx of the shift register; vote_idx=0, ones=0.
  - If chal_idx == RESP_BITS-1 -> DONE. Otherwise chal_idx++, chal = chal+1 mod 2^CHAL_W (wraps 0xFF->0x00 at CHAL_W=8) -> SETUP.
- DONE (1 cycle): response <= shift register, done=1, busy=1, puf_reset=1 -> IDLE.
- response holds its value until the next accepted start, where it clears to 0. It never shows partial results.
- One evaluation takes SETTLE+3 cycles.
- Latency: if start is accepted at edge k, done is high in cycle k + 1 + RESP_BITS*VOTES*(SETTLE+3). With defaults that is k+169.
- start while busy=1 (including the DONE cycle) is ignored, with no queuing.
- start and reset together: reset wins.
- puf_challenge holds its last value in IDLE; it is 0 only after reset.
- The ones counter is clog2(VOTES+1) bits wide, so it cannot overflow.

Test Plan:
1. Assert reset 2 cycles with start=1 -> busy=0, done=0, response=0, puf_reset=1, puf_run=0, puf_challenge=0; no start is accepted during reset.
2. PUF model with result constant 1; defaults; base 0x10 -> puf_challenge steps 0x10..0x17, each presented 3 times with puf_run high for exactly 4 cycles; done pulses once at start+169; response=0xFF; busy drops the cycle after done.
3. Model result = challenge[0]; base 0x00 -> response=0xAA.
4. Wrap case: model result = challenge[7]; base 0xFC -> challenges FC,FD,FE,FF,00,01,02,03; response=0x0F.
5. Majority voting: vote pattern 1,0,1 per challenge -> response=0xFF; pattern 1,0,0 -> response=0x00. Repeat with VOTES=1, SETTLE=1: pattern 1 -> 0xFF and done at start+33.
6. Start pulse at cycle 20 of an active request -> ignored, with a single done at +169. Then reset at cycle 50 of a new request -> busy=0, puf_reset=1, response=0, no done pulse. A subsequent start completes normally with correct data.
